alu_flag_stage: RTL and testbench
=================================

ALU_FLAG_STAGE -- requirements
Module: alu_flag_stage

Downstream register stage for the 16-bit ALU. Captures result Z and its five flags into a 2-entry valid/ready buffer. Keeps sticky flag and overflow-count status.

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 in_valid  in  1  upstream result valid.
REQ-005 in_ready  out  1  stage can accept; registered, high when buffer not full.
REQ-006 in_z  in  16  ALU result Z.
REQ-007 in_flags  in  5  ALU flags packed {Sign, Zero, Carry, Parity, Overflow}, bit4..bit0.
REQ-008 out_valid  out  1  head entry valid.
REQ-009 out_ready  in  1  downstream accepts head.
REQ-010 out_z  out  16  head result.
REQ-011 out_flags  out  5  head flags, same packing as in_flags.
REQ-012 clr_sticky  in  1  synchronous clear of sticky_flags and ovf_count.
REQ-013 sticky_flags  out  5  bitwise OR of flags of all results accepted since last clear/reset.
REQ-014 ovf_count  out  8  saturating count of accepted results with Overflow=1.

Function
REQ-015 Push SHALL occur when in_valid and in_ready are both 1 at a rising edge. Pop SHALL occur when out_valid and out_ready are both 1 at a rising edge.
REQ-016 Buffer state machine SHALL have the states EMPTY, ONE and FULL, tracking 0, 1 and 2 entries.
- push only: EMPTY->ONE, ONE->FULL.
- pop only: FULL->ONE, ONE->EMPTY.
- push and pop together: state unchanged.
REQ-017 The stage SHALL have a latency of one cycle: data pushed at edge N SHALL appear on out_z/out_flags with out_valid=1 after edge N, when the buffer was EMPTY.
REQ-018 Order SHALL be strictly FIFO; the second entry moves to head on pop with no bubble.
REQ-019 in_ready SHALL be 0 exactly when the state is FULL, so throughput is 1 per cycle while out_ready=1.
REQ-020 in_valid while FULL SHALL be ignored, with no corruption of stored entries.
REQ-021 out_valid SHALL be 1 in ONE and FULL. out_z/out_flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 out_z/out_flags SHALL be don't-care when out_valid=0, but SHALL be driven to 0 by reset.
REQ-023 On each push, sticky_flags SHALL become sticky_flags OR in_flags.
REQ-024 On each push with in_flags[0]=1, ovf_count SHALL increment by 1, saturating at 255 (no wrap).
REQ-025 If clr_sticky=1 and a push occur in the same cycle, the clear SHALL apply first:
- sticky_flags becomes in_flags;
- ovf_count becomes in_flags[0].
REQ-026 clr_sticky SHALL NOT affect buffer contents or handshake signals.
REQ-027 Stored flags SHALL be passed through unmodified; the stage does no recomputation or checking.

Reset
REQ-028 While rst_n=0, the following SHALL hold, asynchronously:
- state=EMPTY;
- out_valid=0;
- out_z=16'h0000, out_flags=5'b0;
- in_ready=0.
REQ-029 in_ready SHALL rise to 1 at the first rising edge after rst_n deasserts.
REQ-030 sticky_flags and ovf_count SHALL be 0 in reset.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered entries and status immediately, with no pending pop completing.

Verification
REQ-032 Single pass: push Z=16'h0001, flags=5'b00010 with out_ready=1 -> next cycle out_valid=1, out_z=16'h0001, out_flags=5'b00010; following cycle out_valid=0.
REQ-033 Backpressure: out_ready=0, push 16'hAAAA then 16'h5555 -> in_ready=0 after second push; third input 16'h1234 ignored; then out_ready=1 -> outputs 16'hAAAA, 16'h5555 in order, and in_ready returns to 1.
REQ-034 Streaming: in_valid=out_ready=1 for 10 cycles with Z=0..9 -> outputs 0..9 on consecutive cycles, in_ready stays 1, no gaps.
REQ-035 Saturation/clear: 300 pushes with Overflow=1 -> ovf_count=255. Then clr_sticky with simultaneous push of flags=5'b01000 -> sticky_flags=5'b01000, ovf_count=0.
REQ-036 Reset mid-operation: FULL buffer, assert rst_n=0 asynchronously between edges -> out_valid=0, out_z=0, sticky_flags=0 immediately. After release -> in_ready=1 one edge later, state EMPTY.

Source files
------------

// File: rtl/alu_flag_stage.sv
// alu_flag_stage: a two-entry valid/ready register stage for the 16-bit ALU.
// It buffers the result Z together with its five flags, {Sign, Zero, Carry,
// Parity, Overflow}, and passes both through unmodified. It also keeps two
// status values: the OR of every accepted flag set since the last clear, and
// a saturating count of accepted results that had Overflow set.
module alu_flag_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_z,
  input  logic [4:0]  in_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_z,
  output logic [4:0]  out_flags,
  input  logic        clr_sticky,
  output logic [4:0]  sticky_flags,
  output logic [7:0]  ovf_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [7:0] OVF_MAX = 8'hFF;

  state_e      state_q,      state_d;
  logic [15:0] head_z_q,     head_z_d;
  logic [4:0]  head_flags_q, head_flags_d;
  logic [15:0] tail_z_q,     tail_z_d;
  logic [4:0]  tail_flags_q, tail_flags_d;
  logic        out_valid_q,  out_valid_d;
  logic        in_ready_q,   in_ready_d;
  logic [4:0]  sticky_q,     sticky_d;
  logic [7:0]  ovf_q,        ovf_d;

  logic        push_s;
  logic        pop_s;
  logic [4:0]  sticky_base_s;
  logic [7:0]  ovf_base_s;

  // Handshakes are qualified by the registered valid and ready outputs.
  assign push_s = in_valid & in_ready_q;
  assign pop_s  = out_valid_q & out_ready;

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_z        = head_z_q;
  assign out_flags    = head_flags_q;
  assign sticky_flags = sticky_q;
  assign ovf_count    = ovf_q;

  // Buffer state machine: this computes the next occupancy and the head/tail
  // contents, and it derives both handshake outputs from the next state.
  always_comb begin
    state_d      = state_q;
    head_z_d     = head_z_q;
    head_flags_d = head_flags_q;
    tail_z_d     = tail_z_q;
    tail_flags_d = tail_flags_q;
    case (state_q)
      ST_EMPTY: begin
        if (push_s) begin
          head_z_d     = in_z;
          head_flags_d = in_flags;
          state_d      = ST_ONE;
        end else begin
          state_d      = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (push_s && pop_s) begin
          // The head leaves and the new entry takes its place directly.
          head_z_d     = in_z;
          head_flags_d = in_flags;
          state_d      = ST_ONE;
        end else if (push_s) begin
          tail_z_d     = in_z;
          tail_flags_d = in_flags;
          state_d      = ST_FULL;
        end else if (pop_s) begin
          state_d      = ST_EMPTY;
        end else begin
          state_d      = ST_ONE;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a pop can occur in this state.
        if (pop_s) begin
          head_z_d     = tail_z_q;
          head_flags_d = tail_flags_q;
          state_d      = ST_ONE;
        end else begin
          state_d      = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  // Sticky status: a clear takes effect first, and then a push in the same
  // cycle is accumulated on top of the cleared value.
  always_comb begin
    if (clr_sticky) begin
      sticky_base_s = 5'b0;
      ovf_base_s    = 8'h00;
    end else begin
      sticky_base_s = sticky_q;
      ovf_base_s    = ovf_q;
    end
    if (push_s) begin
      sticky_d = sticky_base_s | in_flags;
    end else begin
      sticky_d = sticky_base_s;
    end
    if (push_s && in_flags[0] && (ovf_base_s != OVF_MAX)) begin
      ovf_d = ovf_base_s + 8'd1;
    end else begin
      ovf_d = ovf_base_s;
    end
  end

  // State register for all stage storage; reset discards every entry and all
  // status immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      head_z_q     <= 16'h0000;
      head_flags_q <= 5'b0;
      tail_z_q     <= 16'h0000;
      tail_flags_q <= 5'b0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      sticky_q     <= 5'b0;
      ovf_q        <= 8'h00;
    end else begin
      state_q      <= state_d;
      head_z_q     <= head_z_d;
      head_flags_q <= head_flags_d;
      tail_z_q     <= tail_z_d;
      tail_flags_q <= tail_flags_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      sticky_q     <= sticky_d;
      ovf_q        <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_flag_stage.sv
// Directed testbench for alu_flag_stage. The expected values are worked out
// by hand from the intended behaviour of the stage.
module tb_alu_flag_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_z;
  logic [4:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_z;
  logic [4:0]  out_flags;
  logic        clr_sticky;
  logic [4:0]  sticky_flags;
  logic [7:0]  ovf_count;

  int n_cmp = 0;
  int n_err = 0;

  alu_flag_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_z         (in_z),
    .in_flags     (in_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_z        (out_z),
    .out_flags    (out_flags),
    .clr_sticky   (clr_sticky),
    .sticky_flags (sticky_flags),
    .ovf_count    (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then sample 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_z = 16'h0000; in_flags = 5'b0;
    out_ready = 1'b0; clr_sticky = 1'b0;
    #12;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_out_z", {16'd0, out_z}, 32'h0);
    check_eq("rst_out_flags", {27'd0, out_flags}, 32'h0);
    check_eq("rst_sticky", {27'd0, sticky_flags}, 32'h0);
    check_eq("rst_ovf", {24'd0, ovf_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("rel_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rel_out_valid", {31'd0, out_valid}, 32'd0);

    // Single pass through the stage.
    in_valid = 1'b1; in_z = 16'h0001; in_flags = 5'b00010; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("sp_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("sp_out_z", {16'd0, out_z}, 32'h0001);
    check_eq("sp_out_flags", {27'd0, out_flags}, 32'h02);
    check_eq("sp_sticky", {27'd0, sticky_flags}, 32'h02);
    step();
    check_eq("sp_drain", {31'd0, out_valid}, 32'd0);

    // Backpressure: fill the buffer, check that a third push is ignored,
    // then drain in order.
    out_ready = 1'b0;
    in_valid = 1'b1; in_z = 16'hAAAA; in_flags = 5'b10000;
    step();
    check_eq("bp_first_head", {16'd0, out_z}, 32'hAAAA);
    check_eq("bp_ready_one", {31'd0, in_ready}, 32'd1);
    in_z = 16'h5555; in_flags = 5'b00100;
    step();
    check_eq("bp_ready_full", {31'd0, in_ready}, 32'd0);
    in_z = 16'h1234; in_flags = 5'b00001;
    step();
    check_eq("bp_ignored_ready", {31'd0, in_ready}, 32'd0);
    check_eq("bp_hold_z", {16'd0, out_z}, 32'hAAAA);
    check_eq("bp_hold_flags", {27'd0, out_flags}, 32'h10);
    check_eq("bp_ovf_ignored", {24'd0, ovf_count}, 32'd0);
    check_eq("bp_sticky", {27'd0, sticky_flags}, 32'h16);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check_eq("bp_second_z", {16'd0, out_z}, 32'h5555);
    check_eq("bp_second_flags", {27'd0, out_flags}, 32'h04);
    check_eq("bp_second_valid", {31'd0, out_valid}, 32'd1);
    check_eq("bp_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    check_eq("bp_empty", {31'd0, out_valid}, 32'd0);

    // Streaming: one result per cycle with no gaps.
    in_flags = 5'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_z = 16'(i);
      step();
      check_eq("st_valid", {31'd0, out_valid}, 32'd1);
      check_eq("st_z", {16'd0, out_z}, 32'(i));
      check_eq("st_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    check_eq("st_drain", {31'd0, out_valid}, 32'd0);

    // Overflow count saturation followed by a clear with a simultaneous push.
    in_valid = 1'b1; in_flags = 5'b00001;
    for (int i = 0; i < 300; i++) begin
      in_z = 16'(i);
      step();
      if (i == 99) check_eq("sat_mid", {24'd0, ovf_count}, 32'd100);
    end
    check_eq("sat_ovf", {24'd0, ovf_count}, 32'd255);
    check_eq("sat_sticky", {27'd0, sticky_flags}, 32'h17);
    clr_sticky = 1'b1; in_flags = 5'b01000; in_z = 16'h0007;
    step();
    clr_sticky = 1'b0; in_valid = 1'b0;
    check_eq("clr_sticky_push", {27'd0, sticky_flags}, 32'h08);
    check_eq("clr_ovf_push", {24'd0, ovf_count}, 32'd0);
    check_eq("clr_data", {16'd0, out_z}, 32'h0007);
    in_valid = 1'b1; in_flags = 5'b00001;
    step();
    in_valid = 1'b0;
    check_eq("ovf_one", {24'd0, ovf_count}, 32'd1);
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check_eq("clr_alone_sticky", {27'd0, sticky_flags}, 32'h0);
    check_eq("clr_alone_ovf", {24'd0, ovf_count}, 32'd0);
    step();

    // Assert reset asynchronously while the buffer is full.
    out_ready = 1'b0; in_valid = 1'b1; in_flags = 5'b00011;
    in_z = 16'hBEEF;
    step();
    in_z = 16'hCAFE;
    step();
    check_eq("mr_full", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mr_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mr_out_z", {16'd0, out_z}, 32'h0);
    check_eq("mr_sticky", {27'd0, sticky_flags}, 32'h0);
    check_eq("mr_ovf", {24'd0, ovf_count}, 32'h0);
    check_eq("mr_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("mr_rel_ready", {31'd0, in_ready}, 32'd1);
    check_eq("mr_rel_empty", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; in_z = 16'h55AA; in_flags = 5'b00000;
    step();
    in_valid = 1'b0;
    check_eq("mr_post_z", {16'd0, out_z}, 32'h55AA);
    check_eq("mr_post_valid", {31'd0, out_valid}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
